// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encoding, status
// flag record and the WIDTH/SEG legality check.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic bit params_ok(input int unsigned width, input int unsigned seg);
        return (seg != 0) && (width % seg == 0) && (width / seg >= 1) && (width / seg <= 16);
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One SEG-bit slice of the carry chain: adds slice IDX of A and effective B plus
// the incoming carry, and registers the partial sum, carry, valid and operands.
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_i,
    input  logic             vld_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    output logic             vld_o,
    output logic             cout_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o
);

    localparam int LO = IDX * SEG;

    logic [SEG:0]     slice_d;
    logic [WIDTH-1:0] sum_d;
    logic             vld_q;
    logic             cout_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_comb begin
        sum_d   = sum_i;
        slice_d = {1'b0, a_i[LO +: SEG]} + {1'b0, b_i[LO +: SEG]} + {{SEG{1'b0}}, cin_i};
        sum_d[LO +: SEG] = slice_d[SEG-1:0];
    end

    // Result fields only load on a valid beat so the output holds its last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= 1'b0;
            cout_q <= 1'b0;
            sum_q  <= '0;
        end else if (adv_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                cout_q <= slice_d[SEG];
                sum_q  <= sum_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv_i && vld_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
    end

    assign vld_o  = vld_q;
    assign cout_o = cout_q;
    assign sum_o  = sum_q;
    assign a_o    = a_q;
    assign b_o    = b_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub with valid/ready handshake and status flags;
// the carry chain is cut into WIDTH/SEG registered slices under a global stall.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = WIDTH / SEG;

    if (!params_ok(WIDTH, SEG)) begin : g_param_err
        $error("addsub_pipe: WIDTH must be a multiple of SEG with 1..16 stages");
    end

    logic             advance;
    logic             sub_op;
    logic             vld_c [STAGES+1];
    logic             cy_c  [STAGES+1];
    logic [WIDTH-1:0] a_c   [STAGES+1];
    logic [WIDTH-1:0] b_c   [STAGES+1];
    logic [WIDTH-1:0] s_c   [STAGES+1];
    logic             c_into_msb;
    logic             unused_payload;
    flags_t           flags;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is A + ~B + 1; a borrow-in cancels the +1.
    assign sub_op   = (in_sub == OP_SUB);
    assign vld_c[0] = in_valid;
    assign cy_c[0]  = in_cin ^ sub_op;
    assign a_c[0]   = in_a;
    assign b_c[0]   = in_b ^ {WIDTH{sub_op}};
    assign s_c[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .adv_i  (advance),
            .vld_i  (vld_c[k]),
            .cin_i  (cy_c[k]),
            .a_i    (a_c[k]),
            .b_i    (b_c[k]),
            .sum_i  (s_c[k]),
            .vld_o  (vld_c[k+1]),
            .cout_o (cy_c[k+1]),
            .a_o    (a_c[k+1]),
            .b_o    (b_c[k+1]),
            .sum_o  (s_c[k+1])
        );
    end

    // Carry into the MSB recovered from the final operands and sum bit.
    assign c_into_msb     = a_c[STAGES][WIDTH-1] ^ b_c[STAGES][WIDTH-1] ^ s_c[STAGES][WIDTH-1];
    assign unused_payload = ^{a_c[STAGES], b_c[STAGES]};

    assign flags.carry = cy_c[STAGES];
    assign flags.ovf   = vld_c[STAGES] && (c_into_msb ^ cy_c[STAGES]);
    assign flags.zero  = vld_c[STAGES] && (s_c[STAGES] == '0);

    assign out_valid = vld_c[STAGES];
    assign out_sum   = s_c[STAGES];
    assign out_carry = flags.carry;
    assign out_ovf   = flags.ovf;
    assign out_zero  = flags.zero;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface and status flags. It replaces the fixed 16-bit ripple add/sub datapath in the matrix arithmetic path. The carry chain is split into SEG-bit slices, with one register stage per slice, so wide operands close timing at full clock rate. It sustains one operation per cycle and supports multi-word chaining through a proper carry/borrow input.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG, and 1 ≤ STAGES ≤ 16
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts the beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0 = A+B+cin; 1 = A−B−cin, where cin acts as borrow-in
- in_cin  in  1  carry-in (add) or borrow-in (sub)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result
- out_sum  out  WIDTH  result
- out_carry  out  1  raw carry out of the MSB; for sub, 1 = no borrow
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0

## Operation
- Effective B is in_b XOR {WIDTH{in_sub}}. Effective carry-in is in_cin XOR in_sub.
  - Sub with cin=0 gives A−B.
  - Sub with cin=1 gives A−B−1.
  - Chaining a low word's out_carry into the next word's in_cin works for both add and sub, provided the sub chain feeds ~out_carry. Integrators own that inversion.
- Stage k (0..STAGES−1) adds slice k of A and effective B plus the carry registered from stage k−1. Stage 0 uses the effective carry-in.
- Slices not yet consumed are skewed forward through the pipeline registers alongside the partial sum.
- out_carry is the carry out of bit WIDTH−1.
- out_ovf is the carry into bit WIDTH−1 XOR the carry out of bit WIDTH−1.
- out_zero is computed in the last stage from the final sum.
- Flow control is a global stall: advance = !out_valid || out_ready.
  - in_ready = advance, combinational from out_valid and out_ready.
  - When advance is low, every stage register, including the valid bits, holds.
- A per-stage valid bit travels with the data. Bubbles (in_valid low while advance is high) propagate as invalid stages.
- Results leave in acceptance order; nothing is dropped or duplicated.
- Width rule: internal slice sums are SEG+1 bits wide. No sign extension happens internally; operands are treated as raw WIDTH-bit vectors.

## Timing
- Latency: a beat accepted at edge t (in_valid && in_ready) produces out_valid at edge t+STAGES, provided no stall occurs in between. Each stalled cycle adds one.
- Throughput is one beat per cycle while out_ready is held high.
- Reset values: out_valid=0, out_sum=0, out_carry=0, out_ovf=0, out_zero=0, all stage valid bits=0. in_ready reads 1 during and after reset.
- Reset mid-operation discards all in-flight beats. The first beat accepted after reset deasserts appears STAGES cycles later.
- Simultaneous accept and emit (pipeline full, out_ready=1, in_valid=1) is lossless: the output beat is consumed and the new beat enters stage 0 on the same edge.
- Output data may change only on an edge where out_valid was low or out_ready was high. While out_valid && !out_ready, outputs are stable.
- With STAGES=1 the block degenerates to a single registered adder with latency 1.

## Structure
- Package addsub_pkg holds:
  - the op encoding constants OP_ADD=0, OP_SUB=1;
  - a flags record {carry, ovf, zero};
  - the parameter legality check function (WIDTH % SEG == 0).
- One sub-module, addsub_stage: a SEG-bit slice adder with its registered sum slice, carry, valid and skewed operand payload. It is instantiated STAGES times in a generate loop.
- The top level contains only the B-inversion and carry-in logic, the stall/ready logic and the flag generation.

## Test plan
All scenarios use WIDTH=16, SEG=4, so latency is 4.
- Add 0x7FFF+0x0001, cin=0 → out_sum=0x8000, out_ovf=1, out_carry=0, out_zero=0, appearing exactly 4 cycles after acceptance.
- Sub 0x0000−0x0001, cin=0 → 0xFFFF, carry=0, ovf=0. Sub 0x1234−0x1234, cin=0 → 0x0000, zero=1, carry=1. Sub 0x0000−0x0000, cin=1 → 0xFFFF, carry=0.
- Add 0xFFFF+0x0001, cin=1 → 0x0001, carry=1, ovf=0. Add 0x8000+0x8000 → 0x0000, carry=1, ovf=1, zero=1.
- 32 back-to-back random beats with out_ready toggled pseudo-randomly → results match the reference model in order, with no loss. While out_valid && !out_ready, outputs stay stable.
- Assert reset for one cycle with 3 beats in flight → out_valid=0 on the next cycle and the in-flight beats are never emitted. A new beat accepted afterwards emerges after 4 cycles.
- Parameter sweep with SEG=16 (latency 1) and WIDTH=32, SEG=8 (latency 4) → random add/sub results match the model.
